// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one variable-latency memory between the CPU and the loader port.
// One access at a time; all outputs registered; hung accesses end with an error ack after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic last_grant, owner, win, any_req, timed_out;
  logic [7:0] cnt;
  assign any_req = req0 | req1;
  // on a tie the requester that did not win last time goes next
  assign win = (req0 & req1) ? ~last_grant : req1;
  assign timed_out = cnt == 8'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = any_req ? ACCESS : IDLE;
      ACCESS:  state_n = (mem_ready || timed_out) ? DONE : ACCESS;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= state_n != IDLE;
      case (state)
        IDLE: if (any_req) begin
          owner     <= win;
          mem_en    <= 1'b1;
          mem_we    <= win ? we1 : we0;
          mem_addr  <= win ? addr1 : addr0;
          mem_wdata <= win ? wdata1 : wdata0;
          cnt       <= '0;
        end
        // a ready arriving on the timeout cycle still counts as success
        ACCESS: if (mem_ready || timed_out) begin
          mem_en <= 1'b0;
          rdata  <= (mem_ready && !mem_we) ? mem_rdata : '0;
          err    <= !mem_ready;
          ack0   <= !owner;
          ack1   <= owner;
        end else begin
          cnt <= cnt + 8'd1;
        end
        default: begin
          ack0       <= 1'b0;
          ack1       <= 1'b0;
          rdata      <= '0;
          err        <= 1'b0;
          last_grant <= owner;
        end
      endcase
    end
  end
endmodule
